// File: rtl/lcd_hd44780_pkg.sv
// rtl/lcd_hd44780_pkg.sv - shared types, opcode masks and address helpers for the HD44780 responder
//
// Purpose: state enum, instruction opcode masks, DDRAM line geometry and the
// address-counter helpers (validity check, AC-to-index map, wrap-aware step).
// Ports: none (package).
package lcd_hd44780_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_CLEARING
  } state_e;

  // Instruction opcodes are decoded by their highest set bit.
  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [6:0] LINE0_BASE  = 7'h00;
  localparam logic [6:0] LINE1_BASE  = 7'h40;
  localparam int         LINE_LEN    = 40;
  localparam int         DDRAM_DEPTH = 2 * LINE_LEN;
  localparam logic [7:0] SPACE_CHAR  = 8'h20;

  localparam logic [6:0] LINE0_LAST = LINE0_BASE + 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);

  function automatic logic ac_valid(input logic [6:0] ac);
    return (ac <= LINE0_LAST) || ((ac >= LINE1_BASE) && (ac <= LINE1_LAST));
  endfunction

  // Line 1 addresses fold onto RAM indices 40..79.
  function automatic logic [6:0] ac_to_index(input logic [6:0] ac);
    if (ac >= LINE1_BASE) return ac - LINE1_BASE + 7'(LINE_LEN);
    return ac - LINE0_BASE;
  endfunction

  // Step the AC across the gap between the two lines in either direction.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac == LINE0_LAST) return LINE1_BASE;
      if (ac == LINE1_LAST) return LINE0_BASE;
      return ac + 7'd1;
    end
    if (ac == LINE1_BASE) return LINE0_LAST;
    if (ac == LINE0_BASE) return LINE1_LAST;
    return ac - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_ddram.sv
// rtl/lcd_hd44780_responder_ddram.sv - 80x8 display RAM, one sync write, two async reads
//
// Purpose: character storage for the responder (module lcd_ddram).
// Ports:
//   clk_i                 write clock
//   we_i, waddr_i, wdata_i synchronous write port (index 0..79)
//   raddr_a_i / rdata_a_o asynchronous read port (bus side)
//   raddr_b_i / rdata_b_o asynchronous read port (debug side)
// Out-of-range read indices return 0x00; out-of-range writes are dropped.
module lcd_ddram
  import lcd_hd44780_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [6:0] raddr_a_i,
  output logic [7:0] rdata_a_o,
  input  logic [6:0] raddr_b_i,
  output logic [7:0] rdata_b_o
);

  logic [7:0] mem_q [DDRAM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < 7'(DDRAM_DEPTH))) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = (raddr_a_i < 7'(DDRAM_DEPTH)) ? mem_q[raddr_a_i] : 8'h00;
  assign rdata_b_o = (raddr_b_i < 7'(DDRAM_DEPTH)) ? mem_q[raddr_b_i] : 8'h00;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// rtl/lcd_hd44780_responder.sv - HD44780-compatible device end of the 8-bit LCD bus
//
// Purpose: decodes instruction/data writes on the E fall, answers status and
// data reads, models the busy flag, keeps an 80-byte DDRAM and the AC.
// Ports:
//   clk, reset                 clock, async active-high reset
//   lcd_e, lcd_rs, lcd_rw      host strobes (synchronised internally)
//   lcd_data                   bidirectional bus, driven only during read strobes
//   busy, addr_counter         internal BF and AC
//   protocol_err               sticky error (write while busy, bad DDRAM address)
//   dbg_addr / dbg_data        combinational DDRAM peek by index
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  inout  wire  [7:0] lcd_data,
  output logic       busy,
  output logic [6:0] addr_counter,
  output logic       protocol_err,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [6:0] LAST_INDEX = 7'(DDRAM_DEPTH - 1);

  // Two-flop synchronisers (_s1, _s2) plus one extra stage (_p) so the
  // fall handler sees RS/RW/data from the last cycle E was still high.
  logic       e_s1_q, e_s2_q, e_p_q;
  logic       rs_s1_q, rs_s2_q, rs_p_q;
  logic       rw_s1_q, rw_s2_q, rw_p_q;
  logic [7:0] data_s1_q, data_s2_q, data_p_q;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [6:0]  fill_q, fill_d;
  logic [6:0]  ac_q, ac_d;
  logic        id_q, id_d;
  logic        perr_q, perr_d;
  logic [2:0]  disp_q, disp_d;
  logic [4:0]  func_q, func_d;
  logic        clr_cmd_q, clr_cmd_d;
  logic [7:0]  rd_q, rd_d;

  logic       e_fall, e_rise_early;
  logic       ram_we;
  logic [6:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_s1_q    <= 1'b0;
      e_s2_q    <= 1'b0;
      e_p_q     <= 1'b0;
      rs_s1_q   <= 1'b0;
      rs_s2_q   <= 1'b0;
      rs_p_q    <= 1'b0;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
      rw_p_q    <= 1'b0;
      data_s1_q <= 8'h00;
      data_s2_q <= 8'h00;
      data_p_q  <= 8'h00;
    end else begin
      e_s1_q    <= lcd_e;
      e_s2_q    <= e_s1_q;
      e_p_q     <= e_s2_q;
      rs_s1_q   <= lcd_rs;
      rs_s2_q   <= rs_s1_q;
      rs_p_q    <= rs_s2_q;
      rw_s1_q   <= lcd_rw;
      rw_s2_q   <= rw_s1_q;
      rw_p_q    <= rw_s2_q;
      data_s1_q <= lcd_data;
      data_s2_q <= data_s1_q;
      data_p_q  <= data_s2_q;
    end
  end

  assign e_fall = e_p_q & ~e_s2_q;
  // Latch read data one stage early so it is valid the first cycle the bus is driven.
  assign e_rise_early = e_s1_q & ~e_s2_q;

  lcd_ddram u_ddram (
    .clk_i     (clk),
    .we_i      (ram_we),
    .waddr_i   (ram_waddr),
    .wdata_i   (ram_wdata),
    .raddr_a_i (ac_to_index(ac_q)),
    .rdata_a_o (ram_rdata),
    .raddr_b_i (dbg_addr),
    .rdata_b_o (dbg_data)
  );

  // Reset starts in CLEARING so the RAM is filled with spaces; clr_cmd_q
  // distinguishes this fill (ends in IDLE) from a Clear instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEARING;
      cnt_q     <= 32'd0;
      fill_q    <= 7'd0;
      ac_q      <= LINE0_BASE;
      id_q      <= 1'b1;
      perr_q    <= 1'b0;
      disp_q    <= 3'd0;
      func_q    <= 5'd0;
      clr_cmd_q <= 1'b0;
      rd_q      <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      ac_q      <= ac_d;
      id_q      <= id_d;
      perr_q    <= perr_d;
      disp_q    <= disp_d;
      func_q    <= func_d;
      clr_cmd_q <= clr_cmd_d;
      rd_q      <= rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    ac_d      = ac_q;
    id_d      = id_q;
    perr_d    = perr_q;
    disp_d    = disp_q;
    func_d    = func_q;
    clr_cmd_d = clr_cmd_q;
    rd_d      = rd_q;
    ram_we    = 1'b0;
    ram_waddr = ac_to_index(ac_q);
    ram_wdata = data_p_q;

    if (e_rise_early) rd_d = rs_s1_q ? ram_rdata : {state_q != ST_IDLE, ac_q};

    case (state_q)
      ST_CLEARING: begin
        ram_we    = 1'b1;
        ram_waddr = fill_q;
        ram_wdata = SPACE_CHAR;
        if (fill_q == LAST_INDEX) begin
          if (clr_cmd_q) begin
            // Remaining busy time so the whole Clear totals CLEAR_CYCLES.
            state_d = ST_BUSY;
            cnt_d   = 32'(CLEAR_CYCLES - DDRAM_DEPTH - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 32'd0) state_d = ST_IDLE;
        else cnt_d = cnt_q - 32'd1;
      end
      default: ;
    endcase

    if (e_fall) begin
      if (!rw_p_q) begin
        if (state_q != ST_IDLE) begin
          perr_d = 1'b1;
        end else begin
          state_d = ST_BUSY;
          cnt_d   = 32'(BUSY_CYCLES - 1);
          if (rs_p_q) begin
            ram_we = 1'b1;
            ac_d   = ac_step(ac_q, id_q);
          end else if (|(data_p_q & OP_DDRAM)) begin
            if (ac_valid(data_p_q[6:0])) begin
              ac_d = data_p_q[6:0];
            end else begin
              ac_d   = LINE0_BASE;
              perr_d = 1'b1;
            end
          end else if (|(data_p_q & OP_CGRAM)) begin
            // No CGRAM model.
          end else if (|(data_p_q & OP_FUNC)) begin
            func_d = data_p_q[4:0];
          end else if (|(data_p_q & OP_SHIFT)) begin
            if (!data_p_q[3]) ac_d = ac_step(ac_q, data_p_q[2]);
          end else if (|(data_p_q & OP_DISPLAY)) begin
            disp_d = data_p_q[2:0];
          end else if (|(data_p_q & OP_ENTRY)) begin
            id_d = data_p_q[1];
          end else if (|(data_p_q & OP_HOME)) begin
            ac_d  = LINE0_BASE;
            cnt_d = 32'(CLEAR_CYCLES - 1);
          end else if (|(data_p_q & OP_CLEAR)) begin
            state_d   = ST_CLEARING;
            fill_d    = 7'd0;
            clr_cmd_d = 1'b1;
            ac_d      = LINE0_BASE;
            id_d      = 1'b1;
          end
        end
      end else if (rs_p_q && (state_q == ST_IDLE)) begin
        ac_d = ac_step(ac_q, id_q);
      end
    end
  end

  assign lcd_data     = (e_s2_q && rw_s2_q) ? rd_q : 8'hzz;
  assign busy         = (state_q != ST_IDLE);
  assign addr_counter = ac_q;
  assign protocol_err = perr_q;

endmodule
